// File: rtl/motor_model_sto_pkg.sv
// motor_model_sto_pkg
//   Shared types and constants for the safe-torque-off sequencer.
//   - sto_state_e : sequencer state encoding (also driven out on o_state)
//   - SRC_*       : bit index of each stop requester in the request vectors
//   - N_SRC       : number of dual-channel stop requesters
//   - max_int     : helper used to size the shared delay counter
package motor_model_sto_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    GATE_OFF = 2'd1,
    STOPPED  = 2'd2,
    RELEASE  = 2'd3
  } sto_state_e;

  localparam int SRC_ESL  = 0;
  localparam int SRC_FPGA = 1;
  localparam int SRC_HPS  = 2;
  localparam int N_SRC    = 3;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/motor_model_sto_sync.sv
// motor_model_sto_sync
//   Parameterised-width two-flop synchroniser for asynchronous stop request
//   channels. The reset value is a parameter so each channel can reset to its
//   own "no request" level (0 for the positive channel, 1 for the negative).
// Ports:
//   clk  in   1  destination clock
//   rst  in   1  synchronous, active-high reset
//   d    in   W  asynchronous input vector
//   q    out  W  synchronised output vector
module motor_model_sto_sync
  import motor_model_sto_pkg::*;
#(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_r;
  logic [W-1:0] sync_r;

  // Two back-to-back capture stages to resolve metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/motor_model_sto_sequencer.sv
// motor_model_sto_sequencer
//   Safe-torque-off sequencer between the drive PWM gates and the motor model
//   powerdown/gate conduit. Three dual-channel stop requesters (ESL, FPGA, HPS)
//   are merged into one stop decision. On stop the gates are forced off, and
//   after P_OFF_DELAY+1 cycles powerdown is asserted. Restart requires a re-arm
//   pulse while no stop is present; powerdown is then released and after
//   P_ON_DELAY+1 cycles the gates follow the PWM again.
// Optional feature: define MOTOR_MODEL_STO_DISCREPANCY_EN to enable per-source
//   p/n discrepancy monitoring (sticky o_fault after P_DISC_CYC inconsistent
//   cycles). Without it o_fault is tied to zero.
// Ports:
//   clk            in   1  system clock
//   rst            in   1  synchronous, active-high reset
//   i_req_p        in   3  stop request, positive channel (async)
//   i_req_n        in   3  stop request, complementary channel (async)
//   i_rearm        in   1  single-cycle re-arm pulse
//   i_gates        in   6  PWM gates {w_l,v_l,u_l,w_h,v_h,u_h}
//   o_gates        out  6  gated PWM to motor model
//   o_powerdown_p  out  1  powerdown, active high
//   o_powerdown_n  out  1  powerdown, active low
//   o_state        out  2  current state (sto_state_e)
//   o_cause        out  3  mask of sources that caused the last stop
//   o_fault        out  3  latched discrepancy fault per source
//   o_rearm_ack    out  1  one-cycle pulse on accepted re-arm
module motor_model_sto_sequencer
  import motor_model_sto_pkg::*;
#(
  parameter int P_OFF_DELAY = 16,
  parameter int P_ON_DELAY  = 16,
  parameter int P_DISC_CYC  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] i_req_p,
  input  logic [N_SRC-1:0] i_req_n,
  input  logic             i_rearm,
  input  logic [5:0]       i_gates,
  output logic [5:0]       o_gates,
  output logic             o_powerdown_p,
  output logic             o_powerdown_n,
  output logic [1:0]       o_state,
  output logic [N_SRC-1:0] o_cause,
  output logic [N_SRC-1:0] o_fault,
  output logic             o_rearm_ack
);

  localparam int CW = $clog2(max_int(P_OFF_DELAY, P_ON_DELAY) + 1);

  logic [N_SRC-1:0] sync_p_s;
  logic [N_SRC-1:0] sync_n_s;
  logic [N_SRC-1:0] req_s;
  logic [N_SRC-1:0] fault_s;
  logic             stop_s;
  logic             rearm_ok_s;

  sto_state_e       state_r;
  sto_state_e       state_nx_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_nx_s;
  logic [N_SRC-1:0] cause_r;
  logic [N_SRC-1:0] cause_nx_s;
  logic             ack_r;
  logic             pd_p_r;
  logic             pd_n_r;

  motor_model_sto_sync #(
    .W       (N_SRC),
    .RST_VAL ({N_SRC{1'b0}})
  ) u_sync_p (
    .clk (clk),
    .rst (rst),
    .d   (i_req_p),
    .q   (sync_p_s)
  );

  motor_model_sto_sync #(
    .W       (N_SRC),
    .RST_VAL ({N_SRC{1'b1}})
  ) u_sync_n (
    .clk (clk),
    .rst (rst),
    .d   (i_req_n),
    .q   (sync_n_s)
  );

  // Either channel alone is enough to request stop (fail-safe OR).
  assign req_s  = sync_p_s | ~sync_n_s;
  assign stop_s = (|req_s) | (|fault_s);

  // No request means every pair is consistent, so any latched fault is
  // cleared by this very re-arm and stop is absent after clearing.
  assign rearm_ok_s = (state_r == STOPPED) && i_rearm && !(|req_s);

`ifdef MOTOR_MODEL_STO_DISCREPANCY_EN
  localparam int DCW = $clog2(P_DISC_CYC + 1);

  logic [DCW-1:0]   disc_cnt_r [N_SRC];
  logic [N_SRC-1:0] fault_r;

  // Per-source discrepancy timers and sticky fault flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        disc_cnt_r[i] <= {DCW{1'b0}};
      end
      fault_r <= {N_SRC{1'b0}};
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (sync_p_s[i] == sync_n_s[i]) begin
          if (disc_cnt_r[i] < DCW'(P_DISC_CYC)) begin
            disc_cnt_r[i] <= disc_cnt_r[i] + DCW'(1);
          end else begin
            disc_cnt_r[i] <= disc_cnt_r[i];
          end
        end else begin
          disc_cnt_r[i] <= {DCW{1'b0}};
        end
        if (rearm_ok_s) begin
          fault_r[i] <= 1'b0;
        end else if (disc_cnt_r[i] == DCW'(P_DISC_CYC)) begin
          fault_r[i] <= 1'b1;
        end else begin
          fault_r[i] <= fault_r[i];
        end
      end
    end
  end

  assign fault_s = fault_r;
`else
  assign fault_s = {N_SRC{1'b0}};
`endif

  // Next-state, delay counter and cause/ack decode.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    cause_nx_s = cause_r;
    case (state_r)
      RUN: begin
        if (stop_s) begin
          state_nx_s = GATE_OFF;
          cnt_nx_s   = CW'(P_OFF_DELAY);
          cause_nx_s = req_s | fault_s;
        end else begin
          state_nx_s = RUN;
        end
      end
      GATE_OFF: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nx_s = STOPPED;
        end else begin
          cnt_nx_s = cnt_r - CW'(1);
        end
      end
      STOPPED: begin
        if (rearm_ok_s) begin
          state_nx_s = RELEASE;
          cnt_nx_s   = CW'(P_ON_DELAY);
          cause_nx_s = {N_SRC{1'b0}};
        end else begin
          state_nx_s = STOPPED;
        end
      end
      RELEASE: begin
        if (stop_s) begin
          state_nx_s = GATE_OFF;
          cnt_nx_s   = CW'(P_OFF_DELAY);
          cause_nx_s = req_s | fault_s;
        end else if (cnt_r == {CW{1'b0}}) begin
          state_nx_s = RUN;
        end else begin
          cnt_nx_s = cnt_r - CW'(1);
        end
      end
      default: begin
        state_nx_s = STOPPED;
        cnt_nx_s   = {CW{1'b0}};
      end
    endcase
  end

  // State register plus registered powerdown, cause and ack outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= STOPPED;
      cnt_r   <= {CW{1'b0}};
      cause_r <= {N_SRC{1'b0}};
      ack_r   <= 1'b0;
      pd_p_r  <= 1'b1;
      pd_n_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      cause_r <= cause_nx_s;
      ack_r   <= rearm_ok_s;
      pd_p_r  <= (state_nx_s == STOPPED);
      pd_n_r  <= (state_nx_s != STOPPED);
    end
  end

  // Gates pass straight through in RUN so the PWM path sees no extra latency.
  assign o_gates       = (state_r == RUN) ? i_gates : 6'b000000;
  assign o_powerdown_p = pd_p_r;
  assign o_powerdown_n = pd_n_r;
  assign o_state       = state_r;
  assign o_cause       = cause_r;
  assign o_fault       = fault_s;
  assign o_rearm_ack   = ack_r;

endmodule

// File: tb/tb_motor_model_sto_sequencer.sv
// tb_motor_model_sto_sequencer
//   Directed self-checking bench for motor_model_sto_sequencer with default
//   parameters (P_OFF_DELAY = P_ON_DELAY = 16, P_DISC_CYC = 64).
module tb_motor_model_sto_sequencer;
  import motor_model_sto_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] i_req_p;
  logic [2:0] i_req_n;
  logic       i_rearm;
  logic [5:0] i_gates;
  logic [5:0] o_gates;
  logic       o_powerdown_p;
  logic       o_powerdown_n;
  logic [1:0] o_state;
  logic [2:0] o_cause;
  logic [2:0] o_fault;
  logic       o_rearm_ack;

  int checks;
  int errors;

  motor_model_sto_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .i_req_p       (i_req_p),
    .i_req_n       (i_req_n),
    .i_rearm       (i_rearm),
    .i_gates       (i_gates),
    .o_gates       (o_gates),
    .o_powerdown_p (o_powerdown_p),
    .o_powerdown_n (o_powerdown_n),
    .o_state       (o_state),
    .o_cause       (o_cause),
    .o_fault       (o_fault),
    .o_rearm_ack   (o_rearm_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_req_p = 3'b000; i_req_n = 3'b111; i_rearm = 1'b0; i_gates = 6'h2A;
    tick(3);
    checks++; if (o_state !== STOPPED) begin errors++; $display("FAIL reset_state got %0d exp %0d", o_state, STOPPED); end
    checks++; if (o_powerdown_p !== 1'b1) begin errors++; $display("FAIL reset_pd_p got %0b exp 1", o_powerdown_p); end
    checks++; if (o_powerdown_n !== 1'b0) begin errors++; $display("FAIL reset_pd_n got %0b exp 0", o_powerdown_n); end
    checks++; if (o_gates !== 6'h00) begin errors++; $display("FAIL reset_gates got %h exp 00", o_gates); end
    checks++; if (o_cause !== 3'b000) begin errors++; $display("FAIL reset_cause got %b exp 000", o_cause); end
    checks++; if (o_fault !== 3'b000) begin errors++; $display("FAIL reset_fault got %b exp 000", o_fault); end
    checks++; if (o_rearm_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %0b exp 0", o_rearm_ack); end
    rst = 1'b0;
    tick(3);
    checks++; if (o_state !== STOPPED) begin errors++; $display("FAIL reset_hold got %0d exp %0d", o_state, STOPPED); end
  endtask

  // Re-arm from STOPPED, then 16 more edges in RELEASE, RUN on the 17th.
  task automatic test_rearm_release();
    i_rearm = 1'b1;
    tick(1);
    i_rearm = 1'b0;
    checks++; if (o_rearm_ack !== 1'b1) begin errors++; $display("FAIL rearm_ack got %0b exp 1", o_rearm_ack); end
    checks++; if (o_state !== RELEASE) begin errors++; $display("FAIL rearm_state got %0d exp %0d", o_state, RELEASE); end
    checks++; if (o_powerdown_p !== 1'b0 || o_powerdown_n !== 1'b1) begin errors++; $display("FAIL rearm_pd got p=%0b n=%0b exp p=0 n=1", o_powerdown_p, o_powerdown_n); end
    tick(1);
    checks++; if (o_rearm_ack !== 1'b0) begin errors++; $display("FAIL rearm_ack_pulse got %0b exp 0", o_rearm_ack); end
    for (int k = 2; k <= 16; k++) begin
      checks++; if (o_state !== RELEASE || o_gates !== 6'h00) begin errors++; $display("FAIL release_hold k=%0d state %0d gates %h exp %0d 00", k, o_state, o_gates, RELEASE); end
      tick(1);
    end
    checks++; if (o_state !== RELEASE) begin errors++; $display("FAIL release_last got %0d exp %0d", o_state, RELEASE); end
    tick(1);
    checks++; if (o_state !== RUN) begin errors++; $display("FAIL run_entry got %0d exp %0d", o_state, RUN); end
    checks++; if (o_gates !== 6'h2A) begin errors++; $display("FAIL run_gates got %h exp 2a", o_gates); end
    i_gates = 6'h15;
    #1;
    checks++; if (o_gates !== 6'h15) begin errors++; $display("FAIL run_gates_follow got %h exp 15", o_gates); end
  endtask

  // FPGA stop: gates off exactly 3 edges later, powerdown 17 edges after that.
  task automatic test_stop_latency();
    i_req_p = 3'b010;
    tick(2);
    checks++; if (o_state !== RUN || o_gates !== 6'h15) begin errors++; $display("FAIL stop_early state %0d gates %h exp %0d 15", o_state, o_gates, RUN); end
    tick(1);
    checks++; if (o_gates !== 6'h00) begin errors++; $display("FAIL stop_gates got %h exp 00", o_gates); end
    checks++; if (o_state !== GATE_OFF) begin errors++; $display("FAIL stop_state got %0d exp %0d", o_state, GATE_OFF); end
    checks++; if (o_cause !== 3'b010) begin errors++; $display("FAIL stop_cause got %b exp 010", o_cause); end
    tick(16);
    checks++; if (o_state !== GATE_OFF || o_powerdown_p !== 1'b0) begin errors++; $display("FAIL gateoff_hold state %0d pd %0b exp %0d 0", o_state, o_powerdown_p, GATE_OFF); end
    tick(1);
    checks++; if (o_state !== STOPPED || o_powerdown_p !== 1'b1 || o_powerdown_n !== 1'b0) begin errors++; $display("FAIL stopped_pd state %0d p %0b n %0b exp %0d 1 0", o_state, o_powerdown_p, o_powerdown_n, STOPPED); end
  endtask

  // Re-arm refused while a request persists, accepted once it drops.
  task automatic test_rearm_blocked();
    i_req_p = 3'b100;
    tick(3);
    i_rearm = 1'b1;
    tick(1);
    i_rearm = 1'b0;
    checks++; if (o_rearm_ack !== 1'b0 || o_state !== STOPPED) begin errors++; $display("FAIL rearm_blocked ack %0b state %0d exp 0 %0d", o_rearm_ack, o_state, STOPPED); end
    tick(1);
    checks++; if (o_rearm_ack !== 1'b0 || o_cause !== 3'b010) begin errors++; $display("FAIL rearm_blocked2 ack %0b cause %b exp 0 010", o_rearm_ack, o_cause); end
    i_req_p = 3'b000;
    tick(3);
    i_rearm = 1'b1;
    tick(1);
    i_rearm = 1'b0;
    checks++; if (o_rearm_ack !== 1'b1 || o_state !== RELEASE || o_cause !== 3'b000) begin errors++; $display("FAIL rearm_accept ack %0b state %0d cause %b exp 1 %0d 000", o_rearm_ack, o_state, o_cause, RELEASE); end
  endtask

  // ESL n-channel stop while RELEASE counter is at 5.
  task automatic test_release_abort();
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      checks++; if (o_state !== RELEASE || o_gates !== 6'h00) begin errors++; $display("FAIL abort_pre k=%0d state %0d gates %h", k, o_state, o_gates); end
    end
    i_req_n = 3'b110;
    tick(2);
    checks++; if (o_state !== RELEASE || o_gates !== 6'h00) begin errors++; $display("FAIL abort_sync state %0d gates %h exp %0d 00", o_state, o_gates, RELEASE); end
    tick(1);
    checks++; if (o_state !== GATE_OFF || o_cause !== 3'b001 || o_gates !== 6'h00) begin errors++; $display("FAIL abort state %0d cause %b gates %h exp %0d 001 00", o_state, o_cause, o_gates, GATE_OFF); end
    i_req_n = 3'b111;
    tick(17);
    checks++; if (o_state !== STOPPED || o_powerdown_p !== 1'b1) begin errors++; $display("FAIL abort_stopped state %0d pd %0b exp %0d 1", o_state, o_powerdown_p, STOPPED); end
  endtask

  // Re-arm pulses in RELEASE and RUN are ignored.
  task automatic test_rearm_ignored();
    i_rearm = 1'b1;
    tick(1);
    checks++; if (o_rearm_ack !== 1'b1) begin errors++; $display("FAIL ign_setup ack %0b exp 1", o_rearm_ack); end
    tick(1);
    i_rearm = 1'b0;
    checks++; if (o_rearm_ack !== 1'b0 || o_state !== RELEASE) begin errors++; $display("FAIL ign_release ack %0b state %0d exp 0 %0d", o_rearm_ack, o_state, RELEASE); end
    tick(16);
    checks++; if (o_state !== RUN || o_gates !== 6'h15) begin errors++; $display("FAIL ign_run state %0d gates %h exp %0d 15", o_state, o_gates, RUN); end
    i_rearm = 1'b1;
    tick(1);
    i_rearm = 1'b0;
    tick(1);
    checks++; if (o_rearm_ack !== 1'b0 || o_state !== RUN) begin errors++; $display("FAIL ign_in_run ack %0b state %0d exp 0 %0d", o_rearm_ack, o_state, RUN); end
  endtask

  // Source 0 held with p=n=0: stops in both builds, fault only with the feature.
  task automatic test_discrepancy();
    logic [2:0] exp_fault;
`ifdef MOTOR_MODEL_STO_DISCREPANCY_EN
    exp_fault = 3'b001;
`else
    exp_fault = 3'b000;
`endif
    i_req_n = 3'b110;
    tick(3);
    checks++; if (o_state !== GATE_OFF || o_cause !== 3'b001) begin errors++; $display("FAIL disc_stop state %0d cause %b exp %0d 001", o_state, o_cause, GATE_OFF); end
    tick(80);
    checks++; if (o_state !== STOPPED) begin errors++; $display("FAIL disc_stopped got %0d exp %0d", o_state, STOPPED); end
    checks++; if (o_fault !== exp_fault) begin errors++; $display("FAIL disc_fault got %b exp %b", o_fault, exp_fault); end
    i_req_n = 3'b111;
    tick(3);
    i_rearm = 1'b1;
    tick(1);
    i_rearm = 1'b0;
    checks++; if (o_rearm_ack !== 1'b1 || o_fault !== 3'b000 || o_state !== RELEASE) begin errors++; $display("FAIL disc_clear ack %0b fault %b state %0d exp 1 000 %0d", o_rearm_ack, o_fault, o_state, RELEASE); end
  endtask

  // Synchronous reset in the middle of the GATE_OFF count.
  task automatic test_reset_mid();
    tick(17);
    checks++; if (o_state !== RUN) begin errors++; $display("FAIL rmid_run got %0d exp %0d", o_state, RUN); end
    i_req_p = 3'b001;
    tick(3);
    checks++; if (o_state !== GATE_OFF) begin errors++; $display("FAIL rmid_gateoff got %0d exp %0d", o_state, GATE_OFF); end
    tick(5);
    rst = 1'b1;
    tick(1);
    checks++; if (o_state !== STOPPED || o_powerdown_p !== 1'b1 || o_powerdown_n !== 1'b0) begin errors++; $display("FAIL rmid_state state %0d p %0b n %0b exp %0d 1 0", o_state, o_powerdown_p, o_powerdown_n, STOPPED); end
    checks++; if (o_cause !== 3'b000 || o_gates !== 6'h00 || o_fault !== 3'b000) begin errors++; $display("FAIL rmid_clear cause %b gates %h fault %b exp 000 00 000", o_cause, o_gates, o_fault); end
    rst = 1'b0;
    i_req_p = 3'b000;
    tick(3);
    checks++; if (o_state !== STOPPED || o_rearm_ack !== 1'b0) begin errors++; $display("FAIL rmid_after state %0d ack %0b exp %0d 0", o_state, o_rearm_ack, STOPPED); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_rearm_release();
    test_stop_latency();
    test_rearm_blocked();
    test_release_abort();
    test_rearm_ignored();
    test_discrepancy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
